// File: rtl/baw_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : baw_game_ctrl
// Purpose  : Game controller for the two-player Black-and-White card game.
//            Owns the game FSM, per-player remaining-card inventories and
//            colour counts, committed hand cards, round/score counters and
//            the match/game results. Button inputs are level signals; the
//            controller edge-detects them internally.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_CARDS  - cards per player, values 1..NUM_CARDS (odd = black, even = white)
//   ROUNDS     - maximum rounds per game (<= NUM_CARDS)
//   WIN_TARGET - score that ends the game early
// Ports
//   clk, reset_n            - clock (rising edge), asynchronous active-low reset
//   btn_center              - rising edge: start game / resolve match
//   btn_top                 - rising edge: advance / commit selection
//   btn_bottom              - rising edge: abort to IDLE (any state)
//   btn_left / btn_right    - rising edge: enter P1 / P2 card selection
//   sel[NUM_CARDS-1:0]      - card select switches, bit k selects value k+1
//   state[2:0]              - IDLE=0 ROUND=1 BOARD=2 P1_SEL=3 P2_SEL=4 MATCH=5 OVER=6
//   p1_cards / p2_cards     - remaining-card masks
//   p*_black_left/white_left- remaining cards per colour
//   p*_hand_black           - colour of committed hand card
//   p*_committed            - player has committed a card this round
//   round, p1_score, p2_score - rounds completed and scores
//   match_result, game_result - 00 none, 01 P1, 10 P2, 11 draw
//   sel_err                 - one-cycle pulse on a rejected commit
// Configuration
//   BAW_BTN_SYNC_EN - when defined, btn_* and sel pass through 2-flop
//                     synchronisers before edge detection (3-cycle latency).
// ============================================================================
module baw_game_ctrl #(
  parameter int NUM_CARDS  = 9,
  parameter int ROUNDS     = 9,
  parameter int WIN_TARGET = 5,
  localparam int CW = $clog2(NUM_CARDS + 1),
  localparam int RW = $clog2(ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 btn_center,
  input  logic                 btn_top,
  input  logic                 btn_bottom,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic [NUM_CARDS-1:0] sel,
  output logic [2:0]           state,
  output logic [NUM_CARDS-1:0] p1_cards,
  output logic [NUM_CARDS-1:0] p2_cards,
  output logic [CW-1:0]        p1_black_left,
  output logic [CW-1:0]        p1_white_left,
  output logic [CW-1:0]        p2_black_left,
  output logic [CW-1:0]        p2_white_left,
  output logic                 p1_hand_black,
  output logic                 p2_hand_black,
  output logic                 p1_committed,
  output logic                 p2_committed,
  output logic [RW-1:0]        round,
  output logic [RW-1:0]        p1_score,
  output logic [RW-1:0]        p2_score,
  output logic [1:0]           match_result,
  output logic [1:0]           game_result,
  output logic                 sel_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROUND  = 3'd1,
    S_BOARD  = 3'd2,
    S_P1_SEL = 3'd3,
    S_P2_SEL = 3'd4,
    S_MATCH  = 3'd5,
    S_OVER   = 3'd6
  } state_t;

  localparam logic [NUM_CARDS-1:0] C_ALL_CARDS  = {NUM_CARDS{1'b1}};
  localparam logic [NUM_CARDS-1:0] C_SEL_ONE    = NUM_CARDS'(1);
  localparam logic [CW-1:0]        C_BLACK_INIT = CW'((NUM_CARDS + 1) / 2);
  localparam logic [CW-1:0]        C_WHITE_INIT = CW'(NUM_CARDS / 2);
  localparam logic [RW-1:0]        C_ROUND_MAX  = RW'(ROUNDS);
  localparam logic [RW-1:0]        C_WIN        = RW'(WIN_TARGET);
  localparam logic [RW-1:0]        C_SCORE_MAX  = {RW{1'b1}};

  localparam logic [1:0] C_RES_NONE = 2'b00;
  localparam logic [1:0] C_RES_P1   = 2'b01;
  localparam logic [1:0] C_RES_P2   = 2'b10;
  localparam logic [1:0] C_RES_DRAW = 2'b11;

  // Button vector order: {bottom, center, top, left, right}
  logic [4:0]           w_btn_in;
  logic [NUM_CARDS-1:0] w_sel_in;

`ifdef BAW_BTN_SYNC_EN
  logic [4:0]           r_btn_s1;
  logic [4:0]           r_btn_s2;
  logic [NUM_CARDS-1:0] r_sel_s1;
  logic [NUM_CARDS-1:0] r_sel_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
    end else begin
      r_btn_s1 <= {btn_bottom, btn_center, btn_top, btn_left, btn_right};
      r_btn_s2 <= r_btn_s1;
      r_sel_s1 <= sel;
      r_sel_s2 <= r_sel_s1;
    end
  end

  assign w_btn_in = r_btn_s2;
  assign w_sel_in = r_sel_s2;
`else
  assign w_btn_in = {btn_bottom, btn_center, btn_top, btn_left, btn_right};
  assign w_sel_in = sel;
`endif

  // Registered rising-edge detect; the FSM acts on r_edge one cycle later.
  logic [4:0] r_btn_q;
  logic [4:0] r_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_q <= '0;
      r_edge  <= '0;
    end else begin
      r_btn_q <= w_btn_in;
      r_edge  <= w_btn_in & ~r_btn_q;
    end
  end

  // Only the highest-priority edge is acted on in a given cycle.
  logic w_ev_bottom;
  logic w_ev_center;
  logic w_ev_top;
  logic w_ev_left;
  logic w_ev_right;

  assign w_ev_bottom = r_edge[4];
  assign w_ev_center = r_edge[3] & ~r_edge[4];
  assign w_ev_top    = r_edge[2] & ~(|r_edge[4:3]);
  assign w_ev_left   = r_edge[1] & ~(|r_edge[4:2]);
  assign w_ev_right  = r_edge[0] & ~(|r_edge[4:1]);

  // Selected card value and colour; meaningful only when sel is one-hot.
  logic [CW-1:0] w_sel_val;
  logic          w_sel_onehot;
  logic          w_sel_black;
  logic          w_accept_p1;
  logic          w_accept_p2;

  always_comb begin
    w_sel_val = '0;
    for (int k = 0; k < NUM_CARDS; k++) begin
      if (w_sel_in[k]) begin
        w_sel_val = CW'(k + 1);
      end
    end
  end

  assign w_sel_onehot = (w_sel_in != '0) && ((w_sel_in & (w_sel_in - C_SEL_ONE)) == '0);
  assign w_sel_black  = w_sel_val[0];
  assign w_accept_p1  = w_sel_onehot && ((w_sel_in & p1_cards) != '0);
  assign w_accept_p2  = w_sel_onehot && ((w_sel_in & p2_cards) != '0);

  // Committed hand values, kept internally for the match comparison.
  logic [CW-1:0] r_p1_hand;
  logic [CW-1:0] r_p2_hand;
  state_t        r_state;

  assign state = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      p1_cards      <= C_ALL_CARDS;
      p2_cards      <= C_ALL_CARDS;
      p1_black_left <= C_BLACK_INIT;
      p1_white_left <= C_WHITE_INIT;
      p2_black_left <= C_BLACK_INIT;
      p2_white_left <= C_WHITE_INIT;
      r_p1_hand     <= '0;
      r_p2_hand     <= '0;
      p1_hand_black <= 1'b0;
      p2_hand_black <= 1'b0;
      p1_committed  <= 1'b0;
      p2_committed  <= 1'b0;
      round         <= '0;
      p1_score      <= '0;
      p2_score      <= '0;
      match_result  <= C_RES_NONE;
      game_result   <= C_RES_NONE;
      sel_err       <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      if (w_ev_bottom) begin
        // Abort: returning to IDLE restores the full reset picture.
        r_state       <= S_IDLE;
        p1_cards      <= C_ALL_CARDS;
        p2_cards      <= C_ALL_CARDS;
        p1_black_left <= C_BLACK_INIT;
        p1_white_left <= C_WHITE_INIT;
        p2_black_left <= C_BLACK_INIT;
        p2_white_left <= C_WHITE_INIT;
        r_p1_hand     <= '0;
        r_p2_hand     <= '0;
        p1_hand_black <= 1'b0;
        p2_hand_black <= 1'b0;
        p1_committed  <= 1'b0;
        p2_committed  <= 1'b0;
        round         <= '0;
        p1_score      <= '0;
        p2_score      <= '0;
        match_result  <= C_RES_NONE;
        game_result   <= C_RES_NONE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_ev_center) r_state <= S_ROUND;
          end

          S_ROUND: begin
            if (w_ev_top) r_state <= S_BOARD;
          end

          S_BOARD: begin
            if (w_ev_center && p1_committed && p2_committed) begin
              // Resolve the match on the transition into MATCH.
              if (r_p1_hand > r_p2_hand) begin
                match_result <= C_RES_P1;
                if (p1_score != C_SCORE_MAX) p1_score <= p1_score + RW'(1);
              end else if (r_p2_hand > r_p1_hand) begin
                match_result <= C_RES_P2;
                if (p2_score != C_SCORE_MAX) p2_score <= p2_score + RW'(1);
              end else begin
                match_result <= C_RES_DRAW;
              end
              if (round != C_ROUND_MAX) round <= round + RW'(1);
              p1_committed <= 1'b0;
              p2_committed <= 1'b0;
              r_state      <= S_MATCH;
            end else if (w_ev_left && !p1_committed) begin
              r_state <= S_P1_SEL;
            end else if (w_ev_right && !p2_committed) begin
              r_state <= S_P2_SEL;
            end
          end

          S_P1_SEL: begin
            if (w_ev_top) begin
              if (w_accept_p1) begin
                p1_cards      <= p1_cards & ~w_sel_in;
                r_p1_hand     <= w_sel_val;
                p1_hand_black <= w_sel_black;
                if (w_sel_black) begin
                  if (p1_black_left != '0) p1_black_left <= p1_black_left - CW'(1);
                end else begin
                  if (p1_white_left != '0) p1_white_left <= p1_white_left - CW'(1);
                end
                p1_committed <= 1'b1;
                r_state      <= S_BOARD;
              end else begin
                sel_err <= 1'b1;
              end
            end
          end

          S_P2_SEL: begin
            if (w_ev_top) begin
              if (w_accept_p2) begin
                p2_cards      <= p2_cards & ~w_sel_in;
                r_p2_hand     <= w_sel_val;
                p2_hand_black <= w_sel_black;
                if (w_sel_black) begin
                  if (p2_black_left != '0) p2_black_left <= p2_black_left - CW'(1);
                end else begin
                  if (p2_white_left != '0) p2_white_left <= p2_white_left - CW'(1);
                end
                p2_committed <= 1'b1;
                r_state      <= S_BOARD;
              end else begin
                sel_err <= 1'b1;
              end
            end
          end

          S_MATCH: begin
            if (w_ev_top) begin
              if ((round == C_ROUND_MAX) || (p1_score == C_WIN) || (p2_score == C_WIN)) begin
                if (p1_score > p2_score) begin
                  game_result <= C_RES_P1;
                end else if (p2_score > p1_score) begin
                  game_result <= C_RES_P2;
                end else begin
                  game_result <= C_RES_DRAW;
                end
                r_state <= S_OVER;
              end else begin
                match_result <= C_RES_NONE;
                r_state      <= S_ROUND;
              end
            end
          end

          S_OVER: begin
            // Terminal until an abort.
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baw_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_baw_game_ctrl
// Purpose  : Self-checking bench for baw_game_ctrl. A game-rules model kept in
//            plain integers and per-card flags predicts every output after
//            each button press; a constant vector table checks the scripted
//            opening of a game, followed by hand-written corner sequences and
//            randomized presses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baw_game_ctrl;

  localparam int NC = 9;
  localparam int NR = 9;
  localparam int WT = 5;

  // Button codes, bit order {right, left, top, center, bottom}
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_BOT   = 5'b00001;
  localparam logic [4:0] B_CEN   = 5'b00010;
  localparam logic [4:0] B_TOP   = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b10000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_center = 1'b0;
  logic       btn_top = 1'b0;
  logic       btn_bottom = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic [8:0] sel = '0;
  logic [2:0] state;
  logic [8:0] p1_cards, p2_cards;
  logic [3:0] p1_black_left, p1_white_left, p2_black_left, p2_white_left;
  logic       p1_hand_black, p2_hand_black, p1_committed, p2_committed;
  logic [3:0] round, p1_score, p2_score;
  logic [1:0] match_result, game_result;
  logic       sel_err;

  baw_game_ctrl #(.NUM_CARDS(NC), .ROUNDS(NR), .WIN_TARGET(WT)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_center(btn_center), .btn_top(btn_top), .btn_bottom(btn_bottom),
    .btn_left(btn_left), .btn_right(btn_right), .sel(sel),
    .state(state), .p1_cards(p1_cards), .p2_cards(p2_cards),
    .p1_black_left(p1_black_left), .p1_white_left(p1_white_left),
    .p2_black_left(p2_black_left), .p2_white_left(p2_white_left),
    .p1_hand_black(p1_hand_black), .p2_hand_black(p2_hand_black),
    .p1_committed(p1_committed), .p2_committed(p2_committed),
    .round(round), .p1_score(p1_score), .p2_score(p2_score),
    .match_result(match_result), .game_result(game_result), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;   // number of cycles sel_err was seen high

  always @(posedge clk) if (sel_err === 1'b1) err_pulses <= err_pulses + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- game-rules reference model ----------------
  int m_st, m_h1, m_h2, m_rnd, m_s1, m_s2, m_mr, m_gr, m_errs;
  bit m_k1, m_k2;
  bit m_c1 [1:NC];
  bit m_c2 [1:NC];

  task automatic m_init();
    m_st = 0; m_h1 = 0; m_h2 = 0; m_rnd = 0; m_s1 = 0; m_s2 = 0;
    m_mr = 0; m_gr = 0; m_k1 = 0; m_k2 = 0;
    for (int v = 1; v <= NC; v++) begin m_c1[v] = 1; m_c2[v] = 1; end
  endtask

  task automatic m_commit(input int p, input logic [8:0] s);
    int v;
    bit ok;
    v = 0;
    ok = ($countones(s) == 1);
    for (int i = 0; i < NC; i++) if (s[i]) v = i + 1;
    if (ok) ok = (p == 1) ? m_c1[v] : m_c2[v];
    if (!ok) begin
      m_errs++;
    end else begin
      if (p == 1) begin m_c1[v] = 0; m_h1 = v; m_k1 = 1; end
      else        begin m_c2[v] = 0; m_h2 = v; m_k2 = 1; end
      m_st = 2;
    end
  endtask

  task automatic m_apply(input logic [4:0] b, input logic [8:0] s);
    int ev;
    ev = -1;
    for (int i = 0; i < 5; i++) if (b[i] && ev < 0) ev = i;   // 0 = highest priority
    if (ev == 0) begin
      m_init();
    end else begin
      case (m_st)
        0: if (ev == 1) m_st = 1;
        1: if (ev == 2) m_st = 2;
        2: begin
          if (ev == 1 && m_k1 && m_k2) begin
            if (m_h1 > m_h2)      begin m_mr = 1; if (m_s1 < 15) m_s1++; end
            else if (m_h2 > m_h1) begin m_mr = 2; if (m_s2 < 15) m_s2++; end
            else                        m_mr = 3;
            if (m_rnd < NR) m_rnd++;
            m_k1 = 0; m_k2 = 0; m_st = 5;
          end else if (ev == 3 && !m_k1) m_st = 3;
          else if (ev == 4 && !m_k2) m_st = 4;
        end
        3: if (ev == 2) m_commit(1, s);
        4: if (ev == 2) m_commit(2, s);
        5: if (ev == 2) begin
          if (m_rnd == NR || m_s1 == WT || m_s2 == WT) begin
            m_st = 6;
            m_gr = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
          end else begin
            m_st = 1; m_mr = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [8:0] e1, e2;
    int b1, w1, b2, w2;
    e1 = '0; e2 = '0; b1 = 0; w1 = 0; b2 = 0; w2 = 0;
    for (int v = 1; v <= NC; v++) begin
      if (m_c1[v]) begin e1[v-1] = 1'b1; if (v % 2 == 1) b1++; else w1++; end
      if (m_c2[v]) begin e2[v-1] = 1'b1; if (v % 2 == 1) b2++; else w2++; end
    end
    chk({tag, " state"}, int'(state), m_st);
    chk({tag, " p1_cards"}, int'(p1_cards), int'(e1));
    chk({tag, " p2_cards"}, int'(p2_cards), int'(e2));
    chk({tag, " p1_black_left"}, int'(p1_black_left), b1);
    chk({tag, " p1_white_left"}, int'(p1_white_left), w1);
    chk({tag, " p2_black_left"}, int'(p2_black_left), b2);
    chk({tag, " p2_white_left"}, int'(p2_white_left), w2);
    chk({tag, " p1_hand_black"}, int'(p1_hand_black), m_h1 % 2);
    chk({tag, " p2_hand_black"}, int'(p2_hand_black), m_h2 % 2);
    chk({tag, " p1_committed"}, int'(p1_committed), int'(m_k1));
    chk({tag, " p2_committed"}, int'(p2_committed), int'(m_k2));
    chk({tag, " round"}, int'(round), m_rnd);
    chk({tag, " p1_score"}, int'(p1_score), m_s1);
    chk({tag, " p2_score"}, int'(p2_score), m_s2);
    chk({tag, " match_result"}, int'(match_result), m_mr);
    chk({tag, " game_result"}, int'(game_result), m_gr);
    chk({tag, " sel_err_pulses"}, err_pulses, m_errs);
  endtask

  // Press a button combination with sel held, wait for the action to settle.
  task automatic press(input logic [4:0] b, input logic [8:0] s);
    @(negedge clk);
    sel = s;
    {btn_right, btn_left, btn_top, btn_center, btn_bottom} = b;
    repeat (2) @(negedge clk);
    {btn_right, btn_left, btn_top, btn_center, btn_bottom} = B_NONE;
    repeat (4) @(negedge clk);
    m_apply(b, s);
  endtask

  task automatic step(input logic [4:0] b, input logic [8:0] s, input string tag);
    press(b, s);
    check_all(tag);
  endtask

  // ---------------- constant vector table ----------------
  typedef struct {
    logic [4:0] btn;
    logic [8:0] sel;
    int         st;
    logic [8:0] p1c;
    logic [8:0] p2c;
    int         rnd;
    int         s1;
    int         s2;
    int         mr;
    int         errs;
  } vec_t;

  vec_t vt [20];

  initial begin
    logic [4:0] rb;
    logic [8:0] rs;
    int         r;

    vt[0]  = '{B_CEN,   9'h000, 1, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 0};
    vt[1]  = '{B_TOP,   9'h000, 2, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 0};
    vt[2]  = '{B_LEFT,  9'h000, 3, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 0};
    vt[3]  = '{B_TOP,   9'h006, 3, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 1};
    vt[4]  = '{B_TOP,   9'h000, 3, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 2};
    vt[5]  = '{B_TOP,   9'h040, 2, 9'h1BF, 9'h1FF, 0, 0, 0, 0, 2};
    vt[6]  = '{B_LEFT,  9'h040, 2, 9'h1BF, 9'h1FF, 0, 0, 0, 0, 2};
    vt[7]  = '{B_CEN,   9'h040, 2, 9'h1BF, 9'h1FF, 0, 0, 0, 0, 2};
    vt[8]  = '{B_RIGHT, 9'h040, 4, 9'h1BF, 9'h1FF, 0, 0, 0, 0, 2};
    vt[9]  = '{B_TOP,   9'h008, 2, 9'h1BF, 9'h1F7, 0, 0, 0, 0, 2};
    vt[10] = '{B_CEN,   9'h008, 5, 9'h1BF, 9'h1F7, 1, 1, 0, 1, 2};
    vt[11] = '{B_TOP,   9'h000, 1, 9'h1BF, 9'h1F7, 1, 1, 0, 0, 2};
    vt[12] = '{B_TOP,   9'h000, 2, 9'h1BF, 9'h1F7, 1, 1, 0, 0, 2};
    vt[13] = '{B_LEFT,  9'h000, 3, 9'h1BF, 9'h1F7, 1, 1, 0, 0, 2};
    vt[14] = '{B_TOP,   9'h040, 3, 9'h1BF, 9'h1F7, 1, 1, 0, 0, 3};
    vt[15] = '{B_TOP,   9'h010, 2, 9'h1AF, 9'h1F7, 1, 1, 0, 0, 3};
    vt[16] = '{B_RIGHT, 9'h010, 4, 9'h1AF, 9'h1F7, 1, 1, 0, 0, 3};
    vt[17] = '{B_TOP,   9'h010, 2, 9'h1AF, 9'h1E7, 1, 1, 0, 0, 3};
    vt[18] = '{B_CEN,   9'h010, 5, 9'h1AF, 9'h1E7, 2, 1, 0, 3, 3};
    vt[19] = '{B_TOP,   9'h000, 1, 9'h1AF, 9'h1E7, 2, 1, 0, 0, 3};

    m_init();
    m_errs = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state against constants, then full model check.
    chk("reset state", int'(state), 0);
    chk("reset p1_cards", int'(p1_cards), 'h1FF);
    chk("reset p1_black_left", int'(p1_black_left), 5);
    chk("reset p1_white_left", int'(p1_white_left), 4);
    check_all("reset");

    // Scripted opening of a game.
    for (int i = 0; i < 20; i++) begin
      press(vt[i].btn, vt[i].sel);
      chk($sformatf("vec%0d state", i), int'(state), vt[i].st);
      chk($sformatf("vec%0d p1_cards", i), int'(p1_cards), int'(vt[i].p1c));
      chk($sformatf("vec%0d p2_cards", i), int'(p2_cards), int'(vt[i].p2c));
      chk($sformatf("vec%0d round", i), int'(round), vt[i].rnd);
      chk($sformatf("vec%0d p1_score", i), int'(p1_score), vt[i].s1);
      chk($sformatf("vec%0d p2_score", i), int'(p2_score), vt[i].s2);
      chk($sformatf("vec%0d match_result", i), int'(match_result), vt[i].mr);
      chk($sformatf("vec%0d sel_err_pulses", i), err_pulses, vt[i].errs);
      check_all($sformatf("vec%0d", i));
    end

    // Four more P1 wins: (9,8) (8,7) (6,3) (4,2) -> score 5, then OVER.
    begin
      int p1v [4] = '{9, 8, 6, 4};
      int p2v [4] = '{8, 7, 3, 2};
      for (int i = 0; i < 4; i++) begin
        step(B_TOP,   9'h000, "win board");
        step(B_LEFT,  9'h000, "win p1sel");
        step(B_TOP,   9'(1) << (p1v[i] - 1), "win p1commit");
        step(B_RIGHT, 9'h000, "win p2sel");
        step(B_TOP,   9'(1) << (p2v[i] - 1), "win p2commit");
        step(B_CEN,   9'h000, "win match");
        chk("win match_result", int'(match_result), 1);
        step(B_TOP,   9'h000, "win advance");
      end
    end
    chk("over state", int'(state), 6);
    chk("over game_result", int'(game_result), 1);
    chk("over p1_score", int'(p1_score), 5);
    chk("over round", int'(round), 6);
    step(B_CEN,  9'h000, "over hold center");
    step(B_TOP,  9'h000, "over hold top");
    step(B_LEFT, 9'h000, "over hold left");
    chk("over still", int'(state), 6);

    // Abort from OVER.
    step(B_BOT, 9'h000, "abort over");
    chk("abort state", int'(state), 0);
    chk("abort p2_cards", int'(p2_cards), 'h1FF);
    chk("abort game_result", int'(game_result), 0);

    // Simultaneous edges: left beats right; bottom beats center.
    step(B_CEN, 9'h000, "simul round");
    step(B_TOP, 9'h000, "simul board");
    step(B_LEFT | B_RIGHT, 9'h000, "simul lr");
    chk("simul lr state", int'(state), 3);
    step(B_BOT | B_CEN, 9'h000, "simul bc");
    chk("simul bc state", int'(state), 0);

    // Bottom during P2_SEL.
    step(B_CEN,   9'h000, "p2abort round");
    step(B_TOP,   9'h000, "p2abort board");
    step(B_LEFT,  9'h000, "p2abort p1sel");
    step(B_TOP,   9'h100, "p2abort p1commit");
    step(B_RIGHT, 9'h000, "p2abort p2sel");
    chk("p2abort in p2sel", int'(state), 4);
    step(B_BOT,   9'h000, "p2abort bottom");
    chk("p2abort state", int'(state), 0);
    chk("p2abort p1_cards", int'(p1_cards), 'h1FF);
    chk("p2abort p1_committed", int'(p1_committed), 0);

    // Asynchronous reset in MATCH.
    step(B_CEN,   9'h000, "areset round");
    step(B_TOP,   9'h000, "areset board");
    step(B_LEFT,  9'h000, "areset p1sel");
    step(B_TOP,   9'h001, "areset p1commit");
    step(B_RIGHT, 9'h000, "areset p2sel");
    step(B_TOP,   9'h002, "areset p2commit");
    step(B_CEN,   9'h000, "areset match");
    chk("areset match_result", int'(match_result), 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_init();
    chk("areset immediate state", int'(state), 0);
    chk("areset immediate p2_score", int'(p2_score), 0);
    check_all("areset during");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("areset after");

    // Randomized presses against the model.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0)       rb = B_BOT;
      else if (r < 6)   rb = B_CEN;
      else if (r < 22)  rb = B_TOP;
      else if (r < 29)  rb = B_LEFT;
      else if (r < 36)  rb = B_RIGHT;
      else              rb = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 9) < 6) rs = 9'(1) << $urandom_range(0, 8);
      else                          rs = 9'($urandom & 32'h1FF);
      step(rb, rs, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
